// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - RISC-V M stage: data-memory handshake, upstream stall and M/W register.
// Optional abort-on-timeout is enabled by defining MEMSTAGE_TIMEOUT_EN.
module memory_stage #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic [WIDTH-1:0] PCPlus4M,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic             MemWriteM,
    input  logic [1:0]       ResultSrcM,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             StallM,
    output logic [WIDTH-1:0] ALUResultW,
    output logic [WIDTH-1:0] ReadDataW,
    output logic [WIDTH-1:0] PCPlus4W,
    output logic [4:0]       RdW,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic             MemErrW
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state, state_next;
    logic   is_load;
    logic   access;
    logic   timeout;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("memory_stage: TIMEOUT_CYCLES must be in 1..255");
    end

    assign is_load   = (ResultSrcM == 2'b01);
    assign access    = MemWriteM | is_load;
    // Request is gated by reset so the memory sees no access while the core is held.
    assign mem_req   = access & rst;
    assign mem_we    = MemWriteM;
    assign mem_addr  = ALUResultM;
    assign mem_wdata = WriteDataM;
    assign StallM    = access & ~mem_ready & ~timeout;

`ifdef MEMSTAGE_TIMEOUT_EN
    logic [7:0] wait_count;

    assign timeout = (state == WAIT) && (wait_count == 8'(TIMEOUT_CYCLES)) && !mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_count <= 8'd0;
        end else if (state == IDLE && state_next == WAIT) begin
            wait_count <= 8'd0;
        end else if (state == WAIT) begin
            wait_count <= wait_count + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (access && !mem_ready) state_next = WAIT;
            WAIT: if (mem_ready || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // M/W holds while stalled so W-stage forwarding keeps seeing the older result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
            RdW        <= '0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            MemErrW    <= 1'b0;
        end else if (!StallM) begin
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            ResultSrcW <= ResultSrcM;
            if (timeout) begin
                ReadDataW <= '0;
                RegWriteW <= 1'b0;
                MemErrW   <= 1'b1;
            end else begin
                ReadDataW <= is_load ? mem_rdata : '0;
                RegWriteW <= RegWriteM;
                MemErrW   <= 1'b0;
            end
        end
    end

endmodule
